// File: rtl/irq_vector_responder.sv
// 68k interrupt responder: encodes device requests onto IPL and answers IACK cycles
// with a vectored byte (DTACK), an autovector (VPA) or a bus error for spurious levels.
module irq_vector_responder #(
  parameter int unsigned WAIT_STATES  = 1,
  parameter logic [7:0]  VEC_BASE     = 8'h40,
  parameter logic [6:0]  AUTOVEC_MASK = 7'b0000000
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic [6:0] i_IRQ,
  input  logic       i_AS_n,
  input  logic [2:0] i_FC,
  input  logic       i_A19,
  input  logic [2:0] i_A_LOW,
  output logic [2:0] o_IPL_n,
  output logic       o_DTACK_n,
  output logic       o_VPA_n,
  output logic       o_BERR_n,
  output logic [7:0] o_D,
  output logic       o_D_OE,
  output logic [6:0] o_ACK
);

  localparam logic       NO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WS_LAST = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WAIT, S_ACK} state_t;
  typedef enum logic [1:0] {P_VEC, P_AUTO, P_SPUR} path_t;

  state_t     r_state;
  path_t      r_path;
  logic [6:0] r_irq_s1, r_irq_s2;
  logic       r_as_s1, r_as_s2;
  logic       r_armed;
  logic [2:0] r_lvl;
  logic [3:0] r_cnt;
  logic [2:0] r_ipl_n;
  logic       r_dtack_n, r_vpa_n, r_berr_n, r_d_oe;
  logic [7:0] r_d;
  logic [6:0] r_ack;

  logic       w_iack;
  logic [6:0] w_lvl_oh;
  logic [7:0] w_vector;
  path_t      w_path;
  path_t      w_path_sel;
  logic       w_go_ack;

  function automatic logic [2:0] f_prio(input logic [6:0] req);
    logic [2:0] lvl;
    lvl = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (req[i]) lvl = 3'(i + 1);
    end
    return lvl;
  endfunction

  // Two-flop synchronisers; left unreset so a strobe held low through reset stays low.
  always_ff @(posedge i_CLK) begin
    r_irq_s1 <= i_IRQ;
    r_irq_s2 <= r_irq_s1;
    r_as_s1  <= i_AS_n;
    r_as_s2  <= r_as_s1;
  end

  assign w_iack   = r_armed && !r_as_s2 && (i_FC == 3'b111) && i_A19 && (i_A_LOW != 3'd0);
  assign w_lvl_oh = 7'b0000001 << (r_lvl - 3'd1);
  assign w_vector = VEC_BASE + {5'b00000, r_lvl};

  always_comb begin
    w_path = P_VEC;
    if ((r_irq_s2 & w_lvl_oh) == 7'd0) w_path = P_SPUR;
    else if ((AUTOVEC_MASK & w_lvl_oh) != 7'd0) w_path = P_AUTO;
    w_path_sel = (r_state == S_DECODE) ? w_path : r_path;
    w_go_ack   = !r_as_s2 && (((r_state == S_DECODE) && NO_WAIT) ||
                              ((r_state == S_WAIT) && (r_cnt == 4'd0)));
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state   <= S_IDLE;
      r_path    <= P_VEC;
      r_armed   <= 1'b0;
      r_lvl     <= 3'd0;
      r_cnt     <= 4'd0;
      r_ipl_n   <= 3'b111;
      r_dtack_n <= 1'b1;
      r_vpa_n   <= 1'b1;
      r_berr_n  <= 1'b1;
      r_d       <= 8'h00;
      r_d_oe    <= 1'b0;
      r_ack     <= 7'd0;
    end else begin
      r_ack <= 7'd0;
      if (r_as_s2) r_armed <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          r_ipl_n <= ~f_prio(r_irq_s2);
          if (w_iack) begin
            r_lvl   <= i_A_LOW;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_path  <= w_path;
          r_cnt   <= WS_LAST;
          r_state <= r_as_s2 ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (r_as_s2) r_state <= S_IDLE;
          else if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        S_ACK: begin
          if (r_as_s2) begin
            r_dtack_n <= 1'b1;
            r_vpa_n   <= 1'b1;
            r_berr_n  <= 1'b1;
            r_d_oe    <= 1'b0;
            r_d       <= 8'h00;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Entering ACK overrides the WAIT transition chosen above.
      if (w_go_ack) begin
        r_state <= S_ACK;
        unique case (w_path_sel)
          P_VEC: begin
            r_d       <= w_vector;
            r_d_oe    <= 1'b1;
            r_dtack_n <= 1'b0;
            r_ack     <= w_lvl_oh;
          end
          P_AUTO: begin
            r_vpa_n <= 1'b0;
            r_d_oe  <= 1'b0;
            r_ack   <= w_lvl_oh;
          end
          default: r_berr_n <= 1'b0;
        endcase
      end
    end
  end

  assign o_IPL_n   = r_ipl_n;
  assign o_DTACK_n = r_dtack_n;
  assign o_VPA_n   = r_vpa_n;
  assign o_BERR_n  = r_berr_n;
  assign o_D       = r_d;
  assign o_D_OE    = r_d_oe;
  assign o_ACK     = r_ack;

endmodule

// File: tb/tb_irq_vector_responder.sv
// Directed bench for irq_vector_responder: instance A uses default parameters,
// instance B has no wait states, VEC_BASE=8'hFE and level 7 autovectored.
module tb_irq_vector_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] irq;
  logic       as_n;
  logic [2:0] fc;
  logic       a19;
  logic [2:0] a_low;

  logic [2:0] a_ipl_n, b_ipl_n;
  logic       a_dtack_n, a_vpa_n, a_berr_n, a_d_oe;
  logic       b_dtack_n, b_vpa_n, b_berr_n, b_d_oe;
  logic [7:0] a_d, b_d;
  logic [6:0] a_ack, b_ack;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  irq_vector_responder #(
    .WAIT_STATES(1), .VEC_BASE(8'h40), .AUTOVEC_MASK(7'b0000000)
  ) dut_a (
    .i_CLK(clk), .i_RST(rst), .i_IRQ(irq), .i_AS_n(as_n), .i_FC(fc), .i_A19(a19),
    .i_A_LOW(a_low), .o_IPL_n(a_ipl_n), .o_DTACK_n(a_dtack_n), .o_VPA_n(a_vpa_n),
    .o_BERR_n(a_berr_n), .o_D(a_d), .o_D_OE(a_d_oe), .o_ACK(a_ack)
  );

  irq_vector_responder #(
    .WAIT_STATES(0), .VEC_BASE(8'hFE), .AUTOVEC_MASK(7'b1000000)
  ) dut_b (
    .i_CLK(clk), .i_RST(rst), .i_IRQ(irq), .i_AS_n(as_n), .i_FC(fc), .i_A19(a19),
    .i_A_LOW(a_low), .o_IPL_n(b_ipl_n), .o_DTACK_n(b_dtack_n), .o_VPA_n(b_vpa_n),
    .o_BERR_n(b_berr_n), .o_D(b_d), .o_D_OE(b_d_oe), .o_ACK(b_ack)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic iack_start(input logic [2:0] f, input logic [2:0] lvl);
    fc    = f;
    a19   = 1'b1;
    a_low = lvl;
    as_n  = 1'b0;
  endtask

  task automatic iack_end();
    as_n  = 1'b1;
    fc    = 3'b000;
    a19   = 1'b0;
    a_low = 3'd0;
  endtask

  initial begin
    rst = 1'b1; irq = 7'd0; as_n = 1'b1; fc = 3'd0; a19 = 1'b0; a_low = 3'd0;
    tick(3);
    chk("rst_ipl",   {5'd0, a_ipl_n}, 8'h07);
    chk("rst_dtack", {7'd0, a_dtack_n}, 8'h01);
    chk("rst_vpa",   {7'd0, a_vpa_n}, 8'h01);
    chk("rst_berr",  {7'd0, a_berr_n}, 8'h01);
    chk("rst_d",     a_d, 8'h00);
    chk("rst_oe",    {7'd0, a_d_oe}, 8'h00);
    chk("rst_ack",   {1'b0, a_ack}, 8'h00);
    rst = 1'b0;
    tick(2);

    // IPL encoding, 3-clock latency
    irq = 7'b0000100;
    tick(2);
    chk("ipl_lat2", {5'd0, a_ipl_n}, 8'h07);
    tick(1);
    chk("ipl_l3", {5'd0, a_ipl_n}, 8'h04);
    irq = 7'b0100100;
    tick(2);
    chk("ipl_l6_lat2", {5'd0, a_ipl_n}, 8'h04);
    tick(1);
    chk("ipl_l6", {5'd0, a_ipl_n}, 8'h01);
    irq = 7'b0000100;
    tick(3);
    chk("ipl_back_l3", {5'd0, a_ipl_n}, 8'h04);

    // Vectored IACK level 3
    iack_start(3'b111, 3'd3);
    tick(4);
    chk("vec3_a_not_early", {7'd0, a_dtack_n}, 8'h01);
    chk("vec3_b_dtack", {7'd0, b_dtack_n}, 8'h00);
    chk("vec3_b_d", b_d, 8'h01);
    chk("vec3_b_ack", {1'b0, b_ack}, 8'h04);
    tick(1);
    chk("vec3_a_d", a_d, 8'h43);
    chk("vec3_a_oe", {7'd0, a_d_oe}, 8'h01);
    chk("vec3_a_dtack", {7'd0, a_dtack_n}, 8'h00);
    chk("vec3_a_ack", {1'b0, a_ack}, 8'h04);
    chk("vec3_b_ack_done", {1'b0, b_ack}, 8'h00);
    chk("vec3_a_vpa", {7'd0, a_vpa_n}, 8'h01);
    tick(1);
    chk("vec3_a_ack_done", {1'b0, a_ack}, 8'h00);
    irq = 7'd0;
    tick(3);
    chk("vec3_ipl_frozen", {5'd0, a_ipl_n}, 8'h04);
    chk("vec3_hold", {7'd0, a_dtack_n}, 8'h00);
    iack_end();
    tick(2);
    chk("vec3_rel_not_early", {7'd0, a_dtack_n}, 8'h00);
    tick(1);
    chk("vec3_rel_dtack", {7'd0, a_dtack_n}, 8'h01);
    chk("vec3_rel_oe", {7'd0, a_d_oe}, 8'h00);
    chk("vec3_rel_d", a_d, 8'h00);
    chk("vec3_rel_b_dtack", {7'd0, b_dtack_n}, 8'h01);
    tick(1);
    chk("vec3_ipl_resume", {5'd0, a_ipl_n}, 8'h07);

    // Autovector on level 7 (instance B)
    irq = 7'b1000000;
    tick(3);
    iack_start(3'b111, 3'd7);
    tick(4);
    chk("av7_b_vpa", {7'd0, b_vpa_n}, 8'h00);
    chk("av7_b_dtack", {7'd0, b_dtack_n}, 8'h01);
    chk("av7_b_oe", {7'd0, b_d_oe}, 8'h00);
    chk("av7_b_ack", {1'b0, b_ack}, 8'h40);
    tick(1);
    chk("av7_b_ack_done", {1'b0, b_ack}, 8'h00);
    chk("av7_b_vpa_hold", {7'd0, b_vpa_n}, 8'h00);
    chk("av7_a_d", a_d, 8'h47);
    chk("av7_a_vpa", {7'd0, a_vpa_n}, 8'h01);
    iack_end();
    tick(3);
    chk("av7_rel_vpa", {7'd0, b_vpa_n}, 8'h01);

    // Spurious IACK level 2
    irq = 7'd0;
    tick(3);
    iack_start(3'b111, 3'd2);
    tick(4);
    chk("spur_b_berr", {7'd0, b_berr_n}, 8'h00);
    chk("spur_b_ack", {1'b0, b_ack}, 8'h00);
    tick(1);
    chk("spur_a_berr", {7'd0, a_berr_n}, 8'h00);
    chk("spur_a_ack", {1'b0, a_ack}, 8'h00);
    chk("spur_a_dtack", {7'd0, a_dtack_n}, 8'h01);
    chk("spur_a_oe", {7'd0, a_d_oe}, 8'h00);
    chk("spur_ipl", {5'd0, a_ipl_n}, 8'h07);
    iack_end();
    tick(3);
    chk("spur_rel_berr", {7'd0, a_berr_n}, 8'h01);

    // Vector wrap on instance B, level 4
    irq = 7'b0001000;
    tick(3);
    iack_start(3'b111, 3'd4);
    tick(4);
    chk("wrap_b_d", b_d, 8'h02);
    chk("wrap_b_oe", {7'd0, b_d_oe}, 8'h01);
    chk("wrap_b_ack", {1'b0, b_ack}, 8'h08);
    tick(1);
    chk("wrap_a_d", a_d, 8'h44);
    iack_end();
    tick(3);

    // Non-IACK function code and level 0: no response
    iack_start(3'b101, 3'd4);
    tick(6);
    chk("fc101_a_dtack", {7'd0, a_dtack_n}, 8'h01);
    chk("fc101_b_dtack", {7'd0, b_dtack_n}, 8'h01);
    chk("fc101_a_oe", {7'd0, a_d_oe}, 8'h00);
    iack_end();
    tick(3);
    iack_start(3'b111, 3'd0);
    tick(6);
    chk("lvl0_a_dtack", {7'd0, a_dtack_n}, 8'h01);
    chk("lvl0_a_berr", {7'd0, a_berr_n}, 8'h01);
    iack_end();
    tick(3);

    // CPU aborts during WAIT on instance A
    iack_start(3'b111, 3'd4);
    tick(2);
    iack_end();
    tick(3);
    chk("abort_a_dtack", {7'd0, a_dtack_n}, 8'h01);
    chk("abort_a_ack", {1'b0, a_ack}, 8'h00);
    tick(1);
    chk("abort_a_dtack2", {7'd0, a_dtack_n}, 8'h01);
    chk("abort_a_ack2", {1'b0, a_ack}, 8'h00);
    tick(3);

    // Reset during ACK with AS held low
    iack_start(3'b111, 3'd4);
    tick(5);
    chk("rstmid_pre_dtack", {7'd0, a_dtack_n}, 8'h00);
    rst = 1'b1;
    tick(1);
    chk("rstmid_dtack", {7'd0, a_dtack_n}, 8'h01);
    chk("rstmid_d", a_d, 8'h00);
    chk("rstmid_oe", {7'd0, a_d_oe}, 8'h00);
    chk("rstmid_ipl", {5'd0, a_ipl_n}, 8'h07);
    chk("rstmid_b_dtack", {7'd0, b_dtack_n}, 8'h01);
    rst = 1'b0;
    tick(6);
    chk("rstmid_blocked_a", {7'd0, a_dtack_n}, 8'h01);
    chk("rstmid_blocked_b", {7'd0, b_dtack_n}, 8'h01);
    chk("rstmid_blocked_ack", {1'b0, a_ack}, 8'h00);
    iack_end();
    tick(3);
    iack_start(3'b111, 3'd4);
    tick(5);
    chk("rstmid_fresh_dtack", {7'd0, a_dtack_n}, 8'h00);
    chk("rstmid_fresh_d", a_d, 8'h44);
    iack_end();
    tick(3);
    chk("final_dtack", {7'd0, a_dtack_n}, 8'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
